ssd_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for an N-digit seven-segment display.

---
 rtl/ssd_scan_ctrl.sv | 98 +++++++++
 tb/tb_ssd_scan_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// Seven-segment scan controller: steps one digit per prescaler tick and feeds BCD/cs to the
// decoder. Frames are double-buffered and committed only when the scan wraps to digit 0.
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    blank_lz,
  output logic [3:0]              bcd_out,
  output logic                    cs_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_upd
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      run_q, run_d;
  logic                      pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0]   disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0]   shadow_q, shadow_d;
  logic [3:0]                bcd_q, bcd_d;
  logic                      cs_q, cs_d;
  logic [NUM_DIGITS-1:0]     sel_q, sel_d;
  logic                      fu_q, fu_d;

  logic tick, wrap, commit, upper_zero;

  // load is a one-cycle strobe with no backpressure: every asserted cycle is accepted and
  // the newest frame (shadow or same-edge digits_in) is what gets committed.
  always_comb begin
    tick     = (cnt_q == CNT_MAX);
    cnt_d    = tick ? '0 : cnt_q + CW'(1);
    // run_q distinguishes the very first tick, which lights digit 0 without advancing.
    run_d    = run_q | tick;
    wrap     = tick && run_q && (idx_q == IDX_MAX);
    idx_d    = idx_q;
    if (tick && run_q) idx_d = wrap ? '0 : idx_q + IW'(1);

    commit   = wrap && (pend_q || load);
    disp_d   = disp_q;
    if (commit) disp_d = load ? digits_in : shadow_q;
    shadow_d = load ? digits_in : shadow_q;
    pend_d   = commit ? 1'b0 : (load ? 1'b1 : pend_q);

    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx_d) && disp_d[4*j +: 4] != 4'd0) upper_zero = 1'b0;
    end

    bcd_d = disp_d[{idx_d, 2'b00} +: 4];
    cs_d  = (bcd_d <= 4'd9) && !(blank_lz && (idx_d != '0) && upper_zero);
    sel_d = '0;
    sel_d[idx_d] = 1'b1;
    fu_d  = commit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      run_q    <= 1'b0;
      pend_q   <= 1'b0;
      disp_q   <= '0;
      shadow_q <= '0;
      bcd_q    <= '0;
      cs_q     <= 1'b0;
      sel_q    <= '0;
      fu_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      run_q    <= run_d;
      pend_q   <= pend_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      fu_q     <= fu_d;
      if (tick) begin
        bcd_q <= bcd_d;
        cs_q  <= cs_d;
        sel_q <= sel_d;
      end
    end
  end

  assign bcd_out   = bcd_q;
  assign cs_out    = cs_q;
  assign dig_sel   = sel_q;
  assign frame_upd = fu_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl with NUM_DIGITS=4, PRESCALE=4: one scan step every 4 clocks.
module tb_ssd_scan_ctrl;

  localparam int ND = 4;
  localparam int PS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   digits_in = '0;
  logic          blank_lz = 1'b0;
  logic [3:0]    bcd_out;
  logic          cs_out;
  logic [ND-1:0] dig_sel;
  logic          frame_upd;

  int total = 0;
  int bad = 0;
  int fu_cnt = 0;
  logic [9:0] exp_q[$];

  ssd_scan_ctrl #(.NUM_DIGITS(ND), .PRESCALE(PS)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .blank_lz(blank_lz),
    .bcd_out(bcd_out), .cs_out(cs_out), .dig_sel(dig_sel), .frame_upd(frame_upd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_upd === 1'b1) fu_cnt++;

  // Expected word layout: {dig_sel, bcd_out, cs_out, frame_upd}.
  function automatic logic [9:0] ev(input logic [3:0] sel, input logic [3:0] bcd,
                                    input logic cs, input logic fu);
    return {sel, bcd, cs, fu};
  endfunction

  task automatic step(input string name, input logic [9:0] e, input int load_at,
                      input logic [15:0] val);
    logic [9:0] got, want;
    exp_q.push_back(e);
    for (int k = 0; k < PS; k++) begin
      if (k == load_at) begin
        load = 1'b1;
        digits_in = val;
      end
      @(posedge clk);
      #1;
      load = 1'b0;
    end
    got = {dig_sel, bcd_out, cs_out, frame_upd};
    want = exp_q.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got sel=%b bcd=%h cs=%b fu=%b, want sel=%b bcd=%h cs=%b fu=%b",
               name, got[9:6], got[5:2], got[1], got[0], want[9:6], want[5:2], want[1], want[0]);
    end
  endtask

  task automatic release_and_first_tick(input string name);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < PS - 1; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (dig_sel !== 4'b0000) begin
        bad++;
        $display("FAIL %s pre_tick%0d: dig_sel=%b want 0000", name, c, dig_sel);
      end
    end
    // The remaining edge of the first dwell is the first tick.
    exp_q.push_back(ev(4'b0001, 4'h0, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    total++;
    if ({dig_sel, bcd_out, cs_out, frame_upd} !== exp_q[0]) begin
      bad++;
      $display("FAIL %s first_tick: got sel=%b bcd=%h cs=%b fu=%b want sel=0001 bcd=0 cs=1 fu=0",
               name, dig_sel, bcd_out, cs_out, frame_upd);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({dig_sel, bcd_out, cs_out, frame_upd} !== 10'b0) begin
      bad++;
      $display("FAIL reset_outputs: got sel=%b bcd=%h cs=%b fu=%b want all 0",
               dig_sel, bcd_out, cs_out, frame_upd);
    end
    fu_cnt = 0;
    release_and_first_tick("reset");
    step("scan_d1", ev(4'b0010, 4'h0, 1'b1, 1'b0), -1, '0);
    step("scan_d2", ev(4'b0100, 4'h0, 1'b1, 1'b0), -1, '0);
    step("scan_d3", ev(4'b1000, 4'h0, 1'b1, 1'b0), -1, '0);
    step("scan_wrap", ev(4'b0001, 4'h0, 1'b1, 1'b0), -1, '0);
  endtask

  task automatic test_load_commit();
    fu_cnt = 0;
    step("ld_d1", ev(4'b0010, 4'h0, 1'b1, 1'b0), -1, '0);
    step("ld_old_d2", ev(4'b0100, 4'h0, 1'b1, 1'b0), 1, 16'h1234);
    step("ld_old_d3", ev(4'b1000, 4'h0, 1'b1, 1'b0), -1, '0);
    step("ld_new_d0", ev(4'b0001, 4'h4, 1'b1, 1'b1), -1, '0);
    step("ld_new_d1", ev(4'b0010, 4'h3, 1'b1, 1'b0), -1, '0);
    step("ld_new_d2", ev(4'b0100, 4'h2, 1'b1, 1'b0), -1, '0);
    step("ld_new_d3", ev(4'b1000, 4'h1, 1'b1, 1'b0), -1, '0);
    total++;
    if (fu_cnt !== 1) begin
      bad++;
      $display("FAIL ld_pulses: got %0d want 1", fu_cnt);
    end
  endtask

  task automatic test_overwrite();
    fu_cnt = 0;
    step("ow_wrap_nopend", ev(4'b0001, 4'h4, 1'b1, 1'b0), -1, '0);
    step("ow_d1", ev(4'b0010, 4'h3, 1'b1, 1'b0), 1, 16'h1111);
    step("ow_d2", ev(4'b0100, 4'h2, 1'b1, 1'b0), 2, 16'h5678);
    step("ow_d3", ev(4'b1000, 4'h1, 1'b1, 1'b0), -1, '0);
    step("ow_new_d0", ev(4'b0001, 4'h8, 1'b1, 1'b1), -1, '0);
    step("ow_new_d1", ev(4'b0010, 4'h7, 1'b1, 1'b0), -1, '0);
    step("ow_new_d2", ev(4'b0100, 4'h6, 1'b1, 1'b0), -1, '0);
    step("ow_new_d3", ev(4'b1000, 4'h5, 1'b1, 1'b0), -1, '0);
    total++;
    if (fu_cnt !== 1) begin
      bad++;
      $display("FAIL ow_pulses: got %0d want 1", fu_cnt);
    end
  endtask

  task automatic test_blank_lz();
    fu_cnt = 0;
    blank_lz = 1'b1;
    step("lz42_d0", ev(4'b0001, 4'h2, 1'b1, 1'b1), 0, 16'h0042);
    step("lz42_d1", ev(4'b0010, 4'h4, 1'b1, 1'b0), -1, '0);
    step("lz42_d2", ev(4'b0100, 4'h0, 1'b0, 1'b0), -1, '0);
    step("lz42_d3", ev(4'b1000, 4'h0, 1'b0, 1'b0), -1, '0);
    step("lz00_d0", ev(4'b0001, 4'h0, 1'b1, 1'b1), 0, 16'h0000);
    step("lz00_d1", ev(4'b0010, 4'h0, 1'b0, 1'b0), -1, '0);
    step("lz00_d2", ev(4'b0100, 4'h0, 1'b0, 1'b0), -1, '0);
    step("lz00_d3", ev(4'b1000, 4'h0, 1'b0, 1'b0), -1, '0);
    total++;
    if (fu_cnt !== 2) begin
      bad++;
      $display("FAIL lz_pulses: got %0d want 2", fu_cnt);
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_invalid_code();
    // Load lands on the wrap tick itself, so the incoming word goes straight to display.
    step("inv_d0", ev(4'b0001, 4'h3, 1'b1, 1'b1), 3, 16'h00A3);
    step("inv_d1", ev(4'b0010, 4'hA, 1'b0, 1'b0), -1, '0);
    step("inv_d2", ev(4'b0100, 4'h0, 1'b1, 1'b0), -1, '0);
    step("inv_d3", ev(4'b1000, 4'h0, 1'b1, 1'b0), -1, '0);
  endtask

  task automatic test_reset_pending();
    step("rp_d0", ev(4'b0001, 4'h3, 1'b1, 1'b0), -1, '0);
    step("rp_d1", ev(4'b0010, 4'hA, 1'b0, 1'b0), -1, '0);
    step("rp_d2", ev(4'b0100, 4'h0, 1'b1, 1'b0), -1, '0);
    load = 1'b1;
    digits_in = 16'h9999;
    @(posedge clk);
    #1;
    load = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({dig_sel, bcd_out, cs_out, frame_upd} !== 10'b0) begin
      bad++;
      $display("FAIL rp_async_clear: got sel=%b bcd=%h cs=%b fu=%b want all 0",
               dig_sel, bcd_out, cs_out, frame_upd);
    end
    @(posedge clk);
    fu_cnt = 0;
    release_and_first_tick("rp");
    step("rp_s1", ev(4'b0010, 4'h0, 1'b1, 1'b0), -1, '0);
    step("rp_s2", ev(4'b0100, 4'h0, 1'b1, 1'b0), -1, '0);
    step("rp_s3", ev(4'b1000, 4'h0, 1'b1, 1'b0), -1, '0);
    step("rp_wrap", ev(4'b0001, 4'h0, 1'b1, 1'b0), -1, '0);
    step("rp_s5", ev(4'b0010, 4'h0, 1'b1, 1'b0), -1, '0);
    step("rp_s6", ev(4'b0100, 4'h0, 1'b1, 1'b0), -1, '0);
    step("rp_s7", ev(4'b1000, 4'h0, 1'b1, 1'b0), -1, '0);
    total++;
    if (fu_cnt !== 0) begin
      bad++;
      $display("FAIL rp_pulses: got %0d want 0", fu_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    logic [3:0]  d;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < ND; i++) v[4*i +: 4] = 4'($urandom_range(0, 15));
      d = v[3:0];
      step("rnd_d0", ev(4'b0001, d, d < 4'd10, 1'b1), $urandom_range(0, PS - 1), v);
      for (int i = 1; i < ND; i++) begin
        d = v[4*i +: 4];
        step("rnd_dn", ev(4'(1 << i), d, d < 4'd10, 1'b0), -1, '0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_commit();
    test_overwrite();
    test_blank_lz();
    test_invalid_code();
    test_reset_pending();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected: got %0d entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
